gcd_job_scheduler: RTL and testbench
====================================

GCD_JOB_SCHEDULER -- requirements
Module: gcd_job_scheduler

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-low; low at a clk edge forces the reset state.
REQ-004 req0_valid, req1_valid  in  1 each  requester has a job pending.
REQ-005 req0_x, req0_y, req1_x, req1_y  in  4 each  job operands; held stable while valid and not ready.
REQ-006 req0_ready, req1_ready  out  1 each  job accepted this cycle (handshake = valid & ready).
REQ-007 resp0_valid, resp1_valid  out  1 each  one-cycle result pulse to the job owner.
REQ-008 resp_gcd  out  4  result, meaningful only while a resp*_valid is high.
REQ-009 resp_err  out  1  job had a zero operand; meaningful only while a resp*_valid is high.
REQ-010 dp_xin, dp_yin  out  4 each  operands to the GCD datapath, driven from the internal hold registers.
REQ-011 x_sel, y_sel, x_ld, y_ld, d_ld  out  1 each  datapath controls (sel 0 = external input, 1 = difference).
REQ-012 x_neq_y, x_lt_y  in  1 each  datapath comparator flags; dp_out  in  4  datapath result register.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, LOAD, CMP, SUBX, SUBY, STORE, RESP.
REQ-015 IDLE: exactly one ready is asserted combinationally, for the granted valid requester; none if no valid.
REQ-016 On handshake: latch operands into hold registers and the owner id; go to LOAD, or to RESP with err set if either operand is 0.
REQ-017 LOAD: x_sel=0, y_sel=0, x_ld=1, y_ld=1 for one cycle; then CMP.
REQ-018 CMP: no loads; x_neq_y=0 -> STORE; x_neq_y=1 & x_lt_y=1 -> SUBY; x_neq_y=1 & x_lt_y=0 -> SUBX.
REQ-019 SUBX: x_sel=1, x_ld=1 (x <= x-y); SUBY: y_sel=1, y_ld=1 (y <= y-x); both return to CMP.
REQ-020 STORE: d_ld=1 for one cycle; then RESP.
REQ-021 RESP: owner's resp*_valid=1 for one cycle; resp_gcd=dp_out, resp_err=0; zero-operand job: resp_gcd=0, resp_err=1; then IDLE.
REQ-022 Control outputs not named for a state SHALL be 0 in that state.
REQ-023 Latency, handshake at cycle 0: LOAD 1, first CMP 2; each subtraction adds 2 cycles; STORE then RESP; equal operands give RESP at cycle 4; zero-operand job gives RESP at cycle 1.
REQ-024 No new job is accepted from LOAD through RESP; a new handshake is possible in the cycle after RESP.
REQ-025 Only one resp*_valid SHALL be high in any cycle, and only in RESP.
REQ-026 Worst case (15,1): 14 subtractions, RESP at cycle 32; no further bound needed for 4-bit operands.

Reset
REQ-027 Reset low: state=IDLE; hold registers, owner id and last-grant register (=1, so req0 is first) cleared/set accordingly.
REQ-028 During and after reset, all outputs SHALL be 0 except req*_ready per REQ-015 once reset is high.
REQ-029 Reset mid-job drops the job silently: no response pulse, and the requester must resubmit.

Configuration
REQ-030 Macro GCD_RR_EN defined: round-robin; when both are valid in IDLE, grant the requester not granted last; last-grant updates on each handshake.
REQ-031 GCD_RR_EN undefined: fixed priority; req0 always wins ties; no last-grant register is built.

Verification
REQ-032 req0 (12,8) alone -> req0_ready at cycle 0; resp0_valid, resp_gcd=4, resp_err=0 at cycle 8.
REQ-033 req1 (6,6) -> resp1_valid at cycle 4, resp_gcd=6; x_sel/y_sel never 1.
REQ-034 req0 (0,5) -> resp0_valid at cycle 1, resp_gcd=0, resp_err=1; x_ld/y_ld never asserted.
REQ-035 Both valid continuously, (9,6) and (15,5) -> RR build: grants alternate 0,1,0; fixed build: req0 served repeatedly and req1 starved.
REQ-036 req0 (15,1), reset low at cycle 10 for one cycle -> no resp pulse, busy=0 at cycle 11, and a new job is accepted at cycle 11.

Source files
------------

// File: rtl/gcd_job_scheduler_if.sv
// gcd_job_scheduler_if
// Bundles the two requester channels, the response channel and the GCD
// datapath control/status lines of gcd_job_scheduler.
//   slave  : the scheduler itself
//   master : the environment (requesters plus the external GCD datapath)
interface gcd_job_scheduler_if;

    // Requester channels
    logic       req0_valid;
    logic       req1_valid;
    logic [3:0] req0_x;
    logic [3:0] req0_y;
    logic [3:0] req1_x;
    logic [3:0] req1_y;
    logic       req0_ready;
    logic       req1_ready;

    // Response channel, shared result bus with one valid per owner
    logic       resp0_valid;
    logic       resp1_valid;
    logic [3:0] resp_gcd;
    logic       resp_err;

    // Datapath operands and controls (sel 0 = external input, 1 = difference)
    logic [3:0] dp_xin;
    logic [3:0] dp_yin;
    logic       x_sel;
    logic       y_sel;
    logic       x_ld;
    logic       y_ld;
    logic       d_ld;

    // Datapath status
    logic       x_neq_y;
    logic       x_lt_y;
    logic [3:0] dp_out;

    // Scheduler status
    logic       busy;

    modport slave (
        input  req0_valid, req1_valid,
        input  req0_x, req0_y, req1_x, req1_y,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_gcd, resp_err,
        output dp_xin, dp_yin,
        output x_sel, y_sel, x_ld, y_ld, d_ld,
        input  x_neq_y, x_lt_y, dp_out,
        output busy
    );

    modport master (
        output req0_valid, req1_valid,
        output req0_x, req0_y, req1_x, req1_y,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_gcd, resp_err,
        input  dp_xin, dp_yin,
        input  x_sel, y_sel, x_ld, y_ld, d_ld,
        output x_neq_y, x_lt_y, dp_out,
        input  busy
    );

endinterface : gcd_job_scheduler_if

// File: rtl/gcd_job_scheduler.sv
// gcd_job_scheduler
// Accepts GCD jobs from two requesters, sequences an external subtract-based
// GCD datapath through LOAD / CMP / SUBX / SUBY / STORE, and returns the
// result to the job owner as a one-cycle pulse.
// Zero-operand jobs skip the datapath and answer with resp_err=1.
// Build option: define GCD_RR_EN for round-robin arbitration on ties;
// otherwise req0 has fixed priority and no last-grant register is built.
// Reset is synchronous and active-low; while it is low every output is 0.
module gcd_job_scheduler (
    input  logic               clk,
    input  logic               reset,
    gcd_job_scheduler_if.slave bus
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CMP   = 3'd2;
    localparam logic [2:0] S_SUBX  = 3'd3;
    localparam logic [2:0] S_SUBY  = 3'd4;
    localparam logic [2:0] S_STORE = 3'd5;
    localparam logic [2:0] S_RESP  = 3'd6;

    // ------------------------------------------------------------------
    // Registers and internal wires
    // ------------------------------------------------------------------
    logic [2:0] r_state;
    logic [2:0] w_state_nxt;

    logic [3:0] r_x_hold;      // operands of the job in flight
    logic [3:0] r_y_hold;
    logic       r_owner;       // 0 = req0, 1 = req1
    logic       r_err;         // job had a zero operand

    logic       w_any_valid;
    logic       w_grant_id;    // requester selected by the arbiter
    logic       w_idle;        // IDLE and out of reset: able to accept a job
    logic       w_hs;          // handshake this cycle
    logic [3:0] w_x_in;
    logic [3:0] w_y_in;
    logic       w_zero_op;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef GCD_RR_EN
    logic r_last_grant;

    // Round-robin: on a tie grant the requester that did not win last time
    always_comb begin
        // NOTE: every signal driven in always_comb gets a value on every path,
        // otherwise synthesis infers a latch to hold the old value.
        w_grant_id = ~bus.req0_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant_id = ~r_last_grant;
        end
    end

    // Remember the winner of every handshake; reset to 1 so req0 goes first
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
        end else if (w_hs) begin
            r_last_grant <= w_grant_id;
        end
    end
`else
    // Fixed priority: req0 wins whenever it is valid
    always_comb begin
        w_grant_id = ~bus.req0_valid;
    end
`endif

    assign w_any_valid = bus.req0_valid | bus.req1_valid;
    assign w_idle      = reset && (r_state == S_IDLE);
    assign w_hs        = w_idle && w_any_valid;

    // Operand mux for the granted requester
    always_comb begin
        w_x_in = bus.req0_x;
        w_y_in = bus.req0_y;
        if (w_grant_id) begin
            w_x_in = bus.req1_x;
            w_y_in = bus.req1_y;
        end
    end

    assign w_zero_op = (w_x_in == 4'd0) || (w_y_in == 4'd0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Sequence the datapath; comparator flags only matter in CMP
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_state_nxt = w_zero_op ? S_RESP : S_LOAD;
                end
            end
            S_LOAD: w_state_nxt = S_CMP;
            S_CMP: begin
                if (!bus.x_neq_y) begin
                    w_state_nxt = S_STORE;
                end else if (bus.x_lt_y) begin
                    w_state_nxt = S_SUBY;
                end else begin
                    w_state_nxt = S_SUBX;
                end
            end
            S_SUBX:  w_state_nxt = S_CMP;
            S_SUBY:  w_state_nxt = S_CMP;
            S_STORE: w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and job registers
    // ------------------------------------------------------------------
    // Advance the FSM and capture the job on handshake; reset drops any job
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!reset) begin
            r_state  <= S_IDLE;
            r_x_hold <= 4'd0;
            r_y_hold <= 4'd0;
            r_owner  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_x_hold <= w_x_in;
                r_y_hold <= w_y_in;
                r_owner  <= w_grant_id;
                r_err    <= w_zero_op;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all forced to 0 while reset is low)
    // ------------------------------------------------------------------
    // Ready is combinational in IDLE, only for the granted valid requester
    assign bus.req0_ready = w_hs && !w_grant_id;
    assign bus.req1_ready = w_hs &&  w_grant_id;

    // Datapath controls decoded from state
    assign bus.x_sel = reset && (r_state == S_SUBX);
    assign bus.y_sel = reset && (r_state == S_SUBY);
    assign bus.x_ld  = reset && ((r_state == S_LOAD) || (r_state == S_SUBX));
    assign bus.y_ld  = reset && ((r_state == S_LOAD) || (r_state == S_SUBY));
    assign bus.d_ld  = reset && (r_state == S_STORE);

    assign bus.dp_xin = reset ? r_x_hold : 4'd0;
    assign bus.dp_yin = reset ? r_y_hold : 4'd0;

    // One-cycle response to the owner; result bus is 0 outside RESP
    assign bus.resp0_valid = reset && (r_state == S_RESP) && !r_owner;
    assign bus.resp1_valid = reset && (r_state == S_RESP) &&  r_owner;
    assign bus.resp_err    = reset && (r_state == S_RESP) &&  r_err;
    assign bus.resp_gcd    = (reset && (r_state == S_RESP) && !r_err) ? bus.dp_out : 4'd0;

    assign bus.busy = reset && (r_state != S_IDLE);

endmodule : gcd_job_scheduler

// File: tb/tb_gcd_job_scheduler.sv
// tb_gcd_job_scheduler
// Directed bench for gcd_job_scheduler. Models the external GCD datapath
// (x/y/d registers plus comparators) and checks handshake, latency, result,
// zero-operand error path, arbitration (build-dependent via GCD_RR_EN) and
// mid-job reset. Cycle 0 is the cycle in which the handshake occurs.
module tb_gcd_job_scheduler;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    gcd_job_scheduler_if bus_if ();

    gcd_job_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // External datapath model: x <= x-y, y <= y-x, d <= x
    logic [3:0] dp_x = 4'd0;
    logic [3:0] dp_y = 4'd0;
    logic [3:0] dp_d = 4'd0;

    always @(posedge clk) begin
        if (bus_if.x_ld) dp_x <= bus_if.x_sel ? dp_x - dp_y : bus_if.dp_xin;
        if (bus_if.y_ld) dp_y <= bus_if.y_sel ? dp_y - dp_x : bus_if.dp_yin;
        if (bus_if.d_ld) dp_d <= dp_x;
    end

    assign bus_if.x_neq_y = (dp_x != dp_y);
    assign bus_if.x_lt_y  = (dp_x <  dp_y);
    assign bus_if.dp_out  = dp_d;

    // ------------------------------------------------------------------
    // Stimulus helpers (no comparisons inside)
    // ------------------------------------------------------------------
    task automatic clear_reqs();
        bus_if.req0_valid = 1'b0;
        bus_if.req1_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_reqs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Present a job mid-cycle; returns #1 later, still in cycle 0
    task automatic start_job(input bit id, input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        if (id) begin
            bus_if.req1_valid = 1'b1;
            bus_if.req1_x     = x;
            bus_if.req1_y     = y;
        end else begin
            bus_if.req0_valid = 1'b1;
            bus_if.req0_x     = x;
            bus_if.req0_y     = y;
        end
        #1;
    endtask

    // Watch cycles 1..max_cyc for a response; cyc = -1 when none arrives
    task automatic wait_resp(input int max_cyc, input bit drop_valid,
                             output int cyc, output logic [1:0] rsp,
                             output logic [3:0] gcd, output logic err,
                             output logic saw_sel, output logic saw_ld,
                             output logic saw_ready, output logic saw_idle);
        cyc = -1; rsp = 2'b00; gcd = 4'd0; err = 1'b0;
        saw_sel = 1'b0; saw_ld = 1'b0; saw_ready = 1'b0; saw_idle = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (c == 1 && drop_valid) clear_reqs();
            #1;
            if (bus_if.x_sel || bus_if.y_sel)           saw_sel   = 1'b1;
            if (bus_if.x_ld  || bus_if.y_ld)            saw_ld    = 1'b1;
            if (bus_if.req0_ready || bus_if.req1_ready) saw_ready = 1'b1;
            if (!bus_if.busy)                           saw_idle  = 1'b1;
            if (bus_if.resp0_valid || bus_if.resp1_valid) begin
                cyc = c;
                rsp = {bus_if.resp1_valid, bus_if.resp0_valid};
                gcd = bus_if.resp_gcd;
                err = bus_if.resp_err;
                break;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        bus_if.req0_valid = 1'b1;
        bus_if.req0_x     = 4'd3;
        bus_if.req0_y     = 4'd4;
        #1;
        n_checks++;
        if (bus_if.req0_ready !== 1'b0) begin
            n_errors++; $display("FAIL reset_ready0: got %b want 0", bus_if.req0_ready);
        end
        n_checks++;
        if (bus_if.busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_busy: got %b want 0", bus_if.busy);
        end
        n_checks++;
        if ({bus_if.x_sel, bus_if.y_sel, bus_if.x_ld, bus_if.y_ld, bus_if.d_ld,
             bus_if.resp0_valid, bus_if.resp1_valid, bus_if.resp_err} !== 8'h00) begin
            n_errors++; $display("FAIL reset_ctl: got %b want 00000000",
                {bus_if.x_sel, bus_if.y_sel, bus_if.x_ld, bus_if.y_ld, bus_if.d_ld,
                 bus_if.resp0_valid, bus_if.resp1_valid, bus_if.resp_err});
        end
        n_checks++;
        if ({bus_if.dp_xin, bus_if.dp_yin, bus_if.resp_gcd} !== 12'h000) begin
            n_errors++; $display("FAIL reset_data: got %h want 000",
                {bus_if.dp_xin, bus_if.dp_yin, bus_if.resp_gcd});
        end
        @(negedge clk);
        clear_reqs();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus_if.req1_ready, bus_if.req0_ready, bus_if.busy} !== 3'b000) begin
            n_errors++; $display("FAIL idle_no_valid: got %b want 000",
                {bus_if.req1_ready, bus_if.req0_ready, bus_if.busy});
        end
        // Mid-cycle valid pulse: ready must follow combinationally
        bus_if.req1_valid = 1'b1;
        #1;
        n_checks++;
        if ({bus_if.req1_ready, bus_if.req0_ready} !== 2'b10) begin
            n_errors++; $display("FAIL idle_ready1: got %b want 10",
                {bus_if.req1_ready, bus_if.req0_ready});
        end
        bus_if.req1_valid = 1'b0;
    endtask

    task automatic test_basic();
        int cyc; logic [1:0] rsp; logic [3:0] gcd; logic err;
        logic s_sel, s_ld, s_rdy, s_idle;
        start_job(1'b0, 4'd12, 4'd8);
        n_checks++;
        if ({bus_if.req1_ready, bus_if.req0_ready} !== 2'b01) begin
            n_errors++; $display("FAIL basic_ready: got %b want 01",
                {bus_if.req1_ready, bus_if.req0_ready});
        end
        wait_resp(40, 1'b1, cyc, rsp, gcd, err, s_sel, s_ld, s_rdy, s_idle);
        n_checks++;
        if (cyc !== 8) begin
            n_errors++; $display("FAIL basic_latency: got %0d want 8", cyc);
        end
        n_checks++;
        if ({rsp, gcd, err} !== {2'b01, 4'd4, 1'b0}) begin
            n_errors++; $display("FAIL basic_resp: got rsp=%b gcd=%0d err=%b want rsp=01 gcd=4 err=0",
                rsp, gcd, err);
        end
        n_checks++;
        if (s_idle !== 1'b0) begin
            n_errors++; $display("FAIL basic_busy: got busy low during job, want high");
        end
        n_checks++;
        if ({bus_if.dp_xin, bus_if.dp_yin} !== {4'd12, 4'd8}) begin
            n_errors++; $display("FAIL basic_hold: got %0d,%0d want 12,8",
                bus_if.dp_xin, bus_if.dp_yin);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({bus_if.busy, bus_if.resp0_valid} !== 2'b00) begin
            n_errors++; $display("FAIL basic_after: got busy/resp0=%b want 00",
                {bus_if.busy, bus_if.resp0_valid});
        end
    endtask

    task automatic test_equal();
        int cyc; logic [1:0] rsp; logic [3:0] gcd; logic err;
        logic s_sel, s_ld, s_rdy, s_idle;
        start_job(1'b1, 4'd6, 4'd6);
        n_checks++;
        if ({bus_if.req1_ready, bus_if.req0_ready} !== 2'b10) begin
            n_errors++; $display("FAIL equal_ready: got %b want 10",
                {bus_if.req1_ready, bus_if.req0_ready});
        end
        wait_resp(40, 1'b1, cyc, rsp, gcd, err, s_sel, s_ld, s_rdy, s_idle);
        n_checks++;
        if (cyc !== 4) begin
            n_errors++; $display("FAIL equal_latency: got %0d want 4", cyc);
        end
        n_checks++;
        if ({rsp, gcd, err} !== {2'b10, 4'd6, 1'b0}) begin
            n_errors++; $display("FAIL equal_resp: got rsp=%b gcd=%0d err=%b want rsp=10 gcd=6 err=0",
                rsp, gcd, err);
        end
        n_checks++;
        if (s_sel !== 1'b0) begin
            n_errors++; $display("FAIL equal_sel: got x_sel/y_sel asserted, want never");
        end
    endtask

    task automatic test_zero();
        int cyc; logic [1:0] rsp; logic [3:0] gcd; logic err;
        logic s_sel, s_ld, s_rdy, s_idle;
        start_job(1'b0, 4'd0, 4'd5);
        n_checks++;
        if (bus_if.req0_ready !== 1'b1) begin
            n_errors++; $display("FAIL zero_ready: got %b want 1", bus_if.req0_ready);
        end
        wait_resp(40, 1'b1, cyc, rsp, gcd, err, s_sel, s_ld, s_rdy, s_idle);
        n_checks++;
        if (cyc !== 1) begin
            n_errors++; $display("FAIL zero_latency: got %0d want 1", cyc);
        end
        n_checks++;
        if ({rsp, gcd, err} !== {2'b01, 4'd0, 1'b1}) begin
            n_errors++; $display("FAIL zero_resp: got rsp=%b gcd=%0d err=%b want rsp=01 gcd=0 err=1",
                rsp, gcd, err);
        end
        n_checks++;
        if (s_ld !== 1'b0) begin
            n_errors++; $display("FAIL zero_ld: got x_ld/y_ld asserted, want never");
        end
    endtask

    task automatic test_worst();
        int cyc; logic [1:0] rsp; logic [3:0] gcd; logic err;
        logic s_sel, s_ld, s_rdy, s_idle;
        start_job(1'b0, 4'd15, 4'd1);
        wait_resp(60, 1'b1, cyc, rsp, gcd, err, s_sel, s_ld, s_rdy, s_idle);
        n_checks++;
        if (cyc !== 32) begin
            n_errors++; $display("FAIL worst_latency: got %0d want 32", cyc);
        end
        n_checks++;
        if ({rsp, gcd, err} !== {2'b01, 4'd1, 1'b0}) begin
            n_errors++; $display("FAIL worst_resp: got rsp=%b gcd=%0d err=%b want rsp=01 gcd=1 err=0",
                rsp, gcd, err);
        end
    endtask

    task automatic test_back_to_back();
        int cyc; logic [1:0] rsp; logic [3:0] gcd; logic err;
        logic s_sel, s_ld, s_rdy, s_idle;
        logic [1:0] exp_oh [3];
`ifdef GCD_RR_EN
        exp_oh = '{2'b01, 2'b10, 2'b01};
`else
        exp_oh = '{2'b01, 2'b01, 2'b01};
`endif
        apply_reset();
        bus_if.req0_valid = 1'b1; bus_if.req0_x = 4'd9;  bus_if.req0_y = 4'd6;
        bus_if.req1_valid = 1'b1; bus_if.req1_x = 4'd15; bus_if.req1_y = 4'd5;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) @(negedge clk);
            #1;
            n_checks++;
            if ({bus_if.req1_ready, bus_if.req0_ready} !== exp_oh[j]) begin
                n_errors++; $display("FAIL b2b_grant%0d: got %b want %b", j,
                    {bus_if.req1_ready, bus_if.req0_ready}, exp_oh[j]);
            end
            wait_resp(40, 1'b0, cyc, rsp, gcd, err, s_sel, s_ld, s_rdy, s_idle);
            n_checks++;
            if (cyc !== 8 || rsp !== exp_oh[j]) begin
                n_errors++; $display("FAIL b2b_resp%0d: got cyc=%0d rsp=%b want cyc=8 rsp=%b",
                    j, cyc, rsp, exp_oh[j]);
            end
            n_checks++;
            if (gcd !== ((exp_oh[j] == 2'b10) ? 4'd5 : 4'd3)) begin
                n_errors++; $display("FAIL b2b_gcd%0d: got %0d want %0d", j, gcd,
                    (exp_oh[j] == 2'b10) ? 5 : 3);
            end
            n_checks++;
            if (s_rdy !== 1'b0) begin
                n_errors++; $display("FAIL b2b_busy_ready%0d: got ready while busy, want none", j);
            end
        end
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_reset_mid_job();
        int cyc; logic [1:0] rsp; logic [3:0] gcd; logic err;
        logic s_sel, s_ld, s_rdy, s_idle;
        logic saw_resp = 1'b0;
        apply_reset();
        start_job(1'b0, 4'd15, 4'd1);
        n_checks++;
        if (bus_if.req0_ready !== 1'b1) begin
            n_errors++; $display("FAIL mid_ready: got %b want 1", bus_if.req0_ready);
        end
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1)  clear_reqs();
            if (c == 10) reset = 1'b0;
            if (c == 11) begin
                reset = 1'b1;
                bus_if.req1_valid = 1'b1;
                bus_if.req1_x     = 4'd6;
                bus_if.req1_y     = 4'd6;
            end
            #1;
            if (bus_if.resp0_valid || bus_if.resp1_valid) saw_resp = 1'b1;
            if (c == 10) begin
                n_checks++;
                if ({bus_if.busy, bus_if.x_ld, bus_if.y_ld, bus_if.x_sel, bus_if.y_sel} !== 5'b0) begin
                    n_errors++; $display("FAIL mid_in_reset: got %b want 00000",
                        {bus_if.busy, bus_if.x_ld, bus_if.y_ld, bus_if.x_sel, bus_if.y_sel});
                end
            end
        end
        n_checks++;
        if ({bus_if.busy, bus_if.req1_ready} !== 2'b01) begin
            n_errors++; $display("FAIL mid_cycle11: got busy/ready1=%b want 01",
                {bus_if.busy, bus_if.req1_ready});
        end
        n_checks++;
        if (saw_resp !== 1'b0) begin
            n_errors++; $display("FAIL mid_no_resp: got response pulse for dropped job, want none");
        end
        wait_resp(40, 1'b1, cyc, rsp, gcd, err, s_sel, s_ld, s_rdy, s_idle);
        n_checks++;
        if (cyc !== 4 || {rsp, gcd, err} !== {2'b10, 4'd6, 1'b0}) begin
            n_errors++; $display("FAIL mid_new_job: got cyc=%0d rsp=%b gcd=%0d err=%b want cyc=4 rsp=10 gcd=6 err=0",
                cyc, rsp, gcd, err);
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------
    initial begin
        clear_reqs();
        bus_if.req0_x = 4'd0; bus_if.req0_y = 4'd0;
        bus_if.req1_x = 4'd0; bus_if.req1_y = 4'd0;
        test_reset();
        test_basic();
        test_equal();
        test_zero();
        test_worst();
        test_back_to_back();
        test_reset_mid_job();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global bound in case the sequence itself stalls
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "timeout");
    end

endmodule : tb_gcd_job_scheduler
